// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, WIDTH clocks per operation.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b (two's complement).
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             ready,
   output logic             busy,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state;
   logic [WIDTH-1:0]   sh_a;
   logic [WIDTH-1:0]   sh_b;
   logic [WIDTH-2:0]   res;
   logic               carry;
   logic [CNT_W-1:0]   cnt;

   logic [WIDTH-1:0]   b_load;
   logic               c_load;
   logic               bit_sum;
   logic               bit_carry;
   logic [WIDTH-1:0]   res_next;

   // Subtraction is a + ~b + 1, so only the loaded operand and carry change.
   always_comb begin
      b_load = b;
      c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
      if (sub) begin
         b_load = ~b;
         c_load = 1'b1;
      end
`endif
   end

   assign bit_sum   = sh_a[0] ^ sh_b[0] ^ carry;
   assign bit_carry = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
   assign res_next  = {bit_sum, res};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         sh_a  <= '0;
         sh_b  <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sh_a  <= a;
                  sh_b  <= b_load;
                  carry <= c_load;
                  cnt   <= '0;
                  ready <= 1'b0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sh_a  <= sh_a >> 1;
               sh_b  <= sh_b >> 1;
               carry <= bit_carry;
               res   <= res_next[WIDTH-1:1];
               cnt   <= cnt + 1'b1;
               // Final bit: publish the full result together with the carry-out.
               if (cnt == LAST_BIT) begin
                  sum   <= res_next;
                  cout  <= bit_carry;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
